// File: rtl/poker_card_rng.sv
// poker_card_rng: free-running LFSR, rejection-sampled card draw (1..CARD_MAX), muxed 2-digit 7-seg readout.
// Define POKER_DECK_NO_REPEAT_EN to deal every card once per deck before any repeats.
module poker_card_rng #(
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
   parameter logic [LFSR_W-1:0] SEED      = 16'h0001,
   parameter int                CARD_MAX  = 13,
   parameter int                MAX_TRIES = 15,
   parameter int                SCAN_W    = 16
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       bin,
   output logic       busy,
   output logic       card_valid,
   output logic [6:0] card,
   output logic [3:0] am,
   output logic [7:0] out
);
   localparam int CW = $clog2(CARD_MAX + 1);
   localparam int TW = MAX_TRIES > 0 ? $clog2(MAX_TRIES + 1) : 1;
   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
   state_t            state_q, state_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic [TW-1:0]     try_q, try_d;
   logic [6:0]        card_q, card_d;
   logic [1:0]        bin_q;
   logic [SCAN_W-1:0] scan_q;
   logic [3:0]        am_q, am_d, digit;
   logic [7:0]        out_q, out_d;
   logic [6:0]        cand, fall;
   logic              ok;
   assign lfsr_d = lfsr_q == '0 ? SEED : {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
   assign cand   = 7'(lfsr_q[CW-1:0]);
`ifdef POKER_DECK_NO_REPEAT_EN
   logic [CARD_MAX-1:0] used_q, used_d;
   logic [127:0]        used_x, set_x;
   // Bit c of used_x tracks card value c, so candidates index it directly.
   assign used_x = 128'({used_q, 1'b0});
   assign set_x  = used_x | (128'd1 << card_d);
   assign ok     = cand != 7'd0 && cand <= 7'(CARD_MAX) && !used_x[cand];
   always_comb begin
      fall = 7'd1;
      for (int i = CARD_MAX; i >= 1; i--) fall = used_x[7'(i)] ? fall : 7'(i);
   end
   always_comb begin
      used_d = used_q;
      if (state_q == DRAW && state_d == DONE) used_d = &set_x[CARD_MAX:1] ? '0 : set_x[CARD_MAX:1];
   end
   always_ff @(posedge clk or posedge clr)
      if (clr) used_q <= '0;
      else used_q <= used_d;
`else
   assign ok   = cand != 7'd0 && cand <= 7'(CARD_MAX);
   assign fall = 7'(int'(cand) % CARD_MAX + 1);
`endif
   always_comb begin
      state_d = state_q;
      try_d   = try_q;
      card_d  = card_q;
      case (state_q)
         IDLE: if (bin_q[0] && !bin_q[1]) begin
            state_d = DRAW;
            try_d   = '0;
         end
         DRAW: if (ok || try_q == TW'(MAX_TRIES)) begin
            state_d = DONE;
            card_d  = ok ? cand : fall;
         end else try_d = try_q + 1'b1;
         default: state_d = IDLE;
      endcase
   end
   // Digit select and segment code come from the same scan bit, registered together.
   assign digit = scan_q[SCAN_W-1] ? 4'(card_q / 7'd10) : 4'(card_q % 7'd10);
   always_comb begin
      am_d  = scan_q[SCAN_W-1] ? 4'b1101 : 4'b1110;
      out_d = 8'b11111111;
      case (digit)
         4'd0: out_d = 8'b00000011;
         4'd1: out_d = 8'b10011111;
         4'd2: out_d = 8'b00100101;
         4'd3: out_d = 8'b00001101;
         4'd4: out_d = 8'b10011001;
         4'd5: out_d = 8'b01001001;
         4'd6: out_d = 8'b01000001;
         4'd7: out_d = 8'b00011111;
         4'd8: out_d = 8'b00000001;
         4'd9: out_d = 8'b00001001;
         default: out_d = 8'b11111111;
      endcase
   end
   always_ff @(posedge clk or posedge clr)
      if (clr) begin
         state_q <= IDLE;
         lfsr_q  <= SEED;
         try_q   <= '0;
         card_q  <= '0;
         bin_q   <= '0;
         scan_q  <= '0;
         am_q    <= 4'b1110;
         out_q   <= 8'b00000011;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         try_q   <= try_d;
         card_q  <= card_d;
         bin_q   <= {bin_q[0], bin};
         scan_q  <= scan_q + 1'b1;
         am_q    <= am_d;
         out_q   <= out_d;
      end
   assign busy       = state_q != IDLE;
   assign card_valid = state_q == DONE;
   assign card       = card_q;
   assign am         = am_q;
   assign out        = out_q;
endmodule

// File: tb/tb_poker_card_rng.sv
// tb_poker_card_rng: table, random and directed draws checked against an array-based LFSR/draw model.
module tb_poker_card_rng;
   localparam int SW = 8;
`ifdef POKER_DECK_NO_REPEAT_EN
   localparam bit DECK = 1'b1;
`else
   localparam bit DECK = 1'b0;
`endif
   localparam logic [7:0] SEG [10] = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001,
                                      8'b01001001, 8'b01000001, 8'b00011111, 8'b00000001, 8'b00001001};
   typedef struct {
      int inst;
      int gap;
      int hold;
      int exp_pulses;
   } vec_t;
   logic       clk = 1'b0, clr = 1'b0, bin0 = 1'b0, bin1 = 1'b0;
   logic       busy0, busy1, cv0, cv1;
   logic [6:0] card0, card1;
   logic [3:0] am0, am1;
   logic [7:0] out0, out1;
   int         total = 0, bad = 0, cyc = 0;
   int         seq [16384];
   bit [100:0] used [2];
   vec_t       tab [6];

   poker_card_rng #(.SCAN_W(SW)) u0 (
      .clk(clk), .clr(clr), .bin(bin0), .busy(busy0), .card_valid(cv0),
      .card(card0), .am(am0), .out(out0)
   );
   poker_card_rng #(.CARD_MAX(2), .MAX_TRIES(0), .SCAN_W(SW)) u1 (
      .clk(clk), .clr(clr), .bin(bin1), .busy(busy1), .card_valid(cv1),
      .card(card1), .am(am1), .out(out1)
   );

   always #5 clk = ~clk;
   always @(posedge clk or posedge clr)
      if (clr) cyc <= 0;
      else cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic setbin(input int inst, input logic v);
      if (inst == 0) bin0 = v;
      else bin1 = v;
   endtask

   function automatic int cv_of(input int inst);
      return inst != 0 ? int'(cv1) : int'(cv0);
   endfunction
   function automatic int busy_of(input int inst);
      return inst != 0 ? int'(busy1) : int'(busy0);
   endfunction
   function automatic int card_of(input int inst);
      return inst != 0 ? int'(card1) : int'(card0);
   endfunction

   // A request raised right after edge n sees candidates seq[n+2], seq[n+3], ...
   function automatic void predict(input int inst, input int n, output int c, output int k);
      int cm, tr, cw, lo;
      bit fin;
      cm = inst != 0 ? 2 : 13;
      tr = inst != 0 ? 0 : 15;
      cw = inst != 0 ? 2 : 4;
      lo = 0; fin = 0; c = 0; k = 0;
      for (int v = cm; v >= 1; v--) if (!used[inst][v]) lo = v;
      for (int t = 0; t <= tr && !fin; t++) begin
         c = seq[n + 2 + t] % (1 << cw);
         k = t;
         if (c >= 1 && c <= cm && !(DECK && used[inst][c])) fin = 1;
         else if (t == tr) begin
            c = DECK ? lo : c % cm + 1;
            fin = 1;
         end
      end
   endfunction

   function automatic void accept(input int inst, input int c);
      int cm, n;
      cm = inst != 0 ? 2 : 13;
      n = 0;
      if (!DECK) return;
      used[inst][c] = 1'b1;
      for (int v = 1; v <= cm; v++) n += int'(used[inst][v]);
      if (n == cm) used[inst] = '0;
   endfunction

   task automatic draw(input int inst, input int n, input int hold, input int exp_pulses,
                       input string nm, output int got);
      int pc, pk, pulses, seen, win;
      setbin(inst, 1'b0);
      if (n <= cyc) n = cyc + 1;
      while (cyc < n) tick;
      predict(inst, n, pc, pk);
      setbin(inst, 1'b1);
      pulses = 0; seen = -1; got = -1;
      win = (hold > 20 ? hold : 20) + 5;
      for (int i = 1; i <= win; i++) begin
         tick;
         if (i == hold) setbin(inst, 1'b0);
         if (i == 2) chk({nm, " busy"}, busy_of(inst), 1);
         if (cv_of(inst) != 0) begin
            pulses++;
            if (seen < 0) begin
               seen = i;
               got = card_of(inst);
            end
         end
      end
      setbin(inst, 1'b0);
      chk({nm, " pulses"}, pulses, exp_pulses);
      chk({nm, " card"}, got, pc);
      chk({nm, " latency"}, seen, 3 + pk);
      chk({nm, " idle"}, busy_of(inst), 0);
      accept(inst, pc);
   endtask

   initial begin
      int pc, pk, got, n, c1110, c1101, cbad, pulses;
      bit found, tdone, odone;
      tab[0] = '{0, 1, 1, 1};
      tab[1] = '{0, 4, 3, 1};
      tab[2] = '{1, 2, 1, 1};
      tab[3] = '{0, 7, 25, 1};
      tab[4] = '{1, 5, 2, 1};
      tab[5] = '{0, 1, 6, 1};
      seq[0] = 1;
      for (int i = 1; i < 16384; i++)
         seq[i] = seq[i-1] == 0 ? 1 : ((seq[i-1] << 1) | ($countones(seq[i-1] & 16'hB400) & 1)) & 16'hFFFF;
      used[0] = '0;
      used[1] = '0;

      #3 clr = 1'b1;
      #1;
      chk("rst card", int'(card0), 0);
      chk("rst busy", int'(busy0), 0);
      chk("rst valid", int'(cv0), 0);
      chk("rst am", int'(am0), 4'b1110);
      chk("rst out", int'(out0), 8'b00000011);
      @(posedge clk);
      #2 clr = 1'b0;

      c1110 = 0; c1101 = 0; cbad = 0;
      for (int m = 1; m <= (1 << SW); m++) begin
         tick;
         if (am0 == 4'b1110) c1110++;
         if (am0 == 4'b1101) c1101++;
         if (out0 != 8'b00000011) cbad++;
      end
      chk("scan ones", c1110, 1 << (SW - 1));
      chk("scan tens", c1101, 1 << (SW - 1));
      chk("scan out zero", cbad, 0);

      found = 0; n = 0;
      for (int m = cyc + 1; m < cyc + 3000 && !found; m++) begin
         predict(0, m, pc, pk);
         if (pc == 12) begin
            found = 1;
            n = m;
         end
      end
      chk("find 12", int'(found), 1);
      draw(0, n, 1, 1, "d12", got);
      tdone = 0; odone = 0;
      for (int i = 0; i < (1 << SW) + 4; i++) begin
         if (am0 == 4'b1101 && !tdone) begin
            chk("tens seg", int'(out0), int'(SEG[1]));
            tdone = 1;
         end
         if (am0 == 4'b1110 && !odone) begin
            chk("ones seg", int'(out0), int'(SEG[2]));
            odone = 1;
         end
         tick;
      end
      chk("both digits seen", int'(tdone && odone), 1);

      found = 0;
      for (int m = cyc + 1; m < cyc + 200 && !found; m++)
         if (seq[m + 2] % 4 == 3) begin
            found = 1;
            n = m;
         end
      chk("find cand3", int'(found), 1);
      draw(1, n, 1, 1, "fallback", got);

      draw(0, cyc + 2, 50, 1, "hold50", got);

      n = cyc + 1;
      while (cyc < n) tick;
      predict(0, n, pc, pk);
      pulses = 0;
      bin0 = 1'b1; tick; if (cv0) pulses++;
      bin0 = 1'b0; tick; if (cv0) pulses++;
      bin0 = 1'b1; tick; if (cv0) pulses++;
      bin0 = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick;
         if (cv0) pulses++;
      end
      chk("busy ignore pulses", pulses, 1);
      chk("busy ignore card", int'(card0), pc);
      accept(0, pc);

      foreach (tab[i]) draw(tab[i].inst, cyc + tab[i].gap, tab[i].hold, tab[i].exp_pulses, "tab", got);

      for (int i = 0; i < 16; i++)
         draw(int'($urandom_range(0, 1)), cyc + int'($urandom_range(1, 15)), int'($urandom_range(1, 6)), 1, "rand", got);

      n = cyc + 1;
      while (cyc < n) tick;
      bin0 = 1'b1; tick; tick;
      chk("pre-clr busy", int'(busy0), 1);
      #3 clr = 1'b1;
      #1;
      chk("clr card", int'(card0), 0);
      chk("clr busy", int'(busy0), 0);
      chk("clr valid", int'(cv0), 0);
      chk("clr am", int'(am0), 4'b1110);
      chk("clr out", int'(out0), 8'b00000011);
      bin0 = 1'b0;
      used[0] = '0;
      used[1] = '0;
      #2 clr = 1'b0;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         tick;
         if (cv0) pulses++;
      end
      chk("clr no pulse", pulses, 0);
      chk("clr card held", int'(card0), 0);

`ifdef POKER_DECK_NO_REPEAT_EN
      begin
         int cnt [2][14];
         int distinct;
         for (int h = 0; h < 2; h++) for (int v = 0; v < 14; v++) cnt[h][v] = 0;
         for (int d = 0; d < 26; d++) begin
            draw(0, cyc + 2, 1, 1, "deck", got);
            if (got >= 1 && got <= 13) cnt[d / 13][got]++;
            if (d == 12) chk("deck mask clear", int'(u0.used_q != '0), 0);
         end
         for (int h = 0; h < 2; h++) begin
            distinct = 0;
            for (int v = 1; v <= 13; v++) if (cnt[h][v] == 1) distinct++;
            chk("deck distinct", distinct, 13);
         end
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/poker_card_rng.md
# poker_card_rng

Parametrised random card generator with a multiplexed two-digit 7-segment readout, succeeding the fixed 4-bit LFSR card demo on the FPGA board. It runs a wide Fibonacci LFSR continuously and, on each draw request, rejection-samples a uniform card value 1..CARD_MAX with a bounded-latency fallback. It then latches the value and drives it as decimal tens/ones digits onto the board's shared anode/segment bus. It sits between the debounced push-button logic, which supplies `bin`, and the display pins.

## Interface
- `LFSR_W`, 16: LFSR width (8..32).
- `TAPS`, 16'hB400: Fibonacci feedback tap mask, bit i = stage i+1.
- `SEED`, 16'h0001: reset value of the LFSR; must be nonzero.
- `CARD_MAX`, 13: highest card value (2..99).
- `MAX_TRIES`, 15: rejected candidates allowed before fallback.
- `SCAN_W`, 16: display scan counter width.
- `clk`  in  1  system clock.
- `clr`  in  1  reset, asynchronous, active-high.
- `bin`  in  1  draw request; sampled on a rising edge, accepted only in IDLE.
- `busy`  out  1  high while a draw is in progress.
- `card_valid`  out  1  one-cycle pulse when `card` updates.
- `card`  out  7  latched card value; 0 = nothing drawn.
- `am`  out  4  digit anodes, active-low; 1110 = ones digit, 1101 = tens digit, bits 3:2 always 1.
- `out`  out  8  segments {a,b,c,d,e,f,g,dp}, active-low.

## Operation
- The LFSR shifts every `clk` regardless of state: `lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)}`. If the register is ever all zeros, it reloads `SEED`.
- Candidate value: `cand = lfsr[CW-1:0]`, where CW = clog2(CARD_MAX+1).
- A candidate is valid when 1 <= cand <= CARD_MAX (and, with DECK_EN, it is not already used).
- The draw state machine has three states: IDLE, DRAW and DONE.
- IDLE:
  - `busy` = 0.
  - A rising edge of `bin` (registered-compare, one-cycle detect) moves to DRAW and clears the try counter.
  - `bin` edges in any other state are dropped.
- DRAW:
  - `busy` = 1.
  - Each cycle, evaluate `cand`.
  - Valid: latch `card <= cand` and go to DONE.
  - Invalid with try counter < MAX_TRIES: increment the counter and stay in DRAW.
  - Invalid with try counter = MAX_TRIES: use the fallback value and go to DONE. The fallback value is `(cand mod CARD_MAX) + 1`; with DECK_EN it is the lowest-numbered unused card.
- DONE: `card_valid` = 1 for this cycle, `busy` = 1; go to IDLE.
- Digit split: `tens = card / 10`, `ones = card % 10`. Combinational from `card`; both digits are always shown, including a leading 0.
- Display scan counter:
  - Free-running, SCAN_W bits.
  - `scan[SCAN_W-1]` = 0 selects ones (`am` = 1110); 1 selects tens (`am` = 1101).
  - `am` and `out` are registered together, so the two never disagree.
- Segment codes, digits 0..9: 00000011, 10011111, 00100101, 00001101, 10011001, 01001001, 01000001, 00011111, 00000001, 00001001. `dp` is always off (1).

## Timing
- Reset values: `busy`=0, `card_valid`=0, `card`=0, `am`=1110, `out`=00000011, state=IDLE, LFSR=SEED, scan=0, deck mask=0.
- Latency from `bin` rising to `card_valid`:
  - Minimum 3 cycles: edge detect, DRAW accept, DONE.
  - Maximum MAX_TRIES+3 cycles.
- `card` changes on the same edge that enters DONE, so it is stable while `card_valid` is high.
- `clr` mid-draw returns to IDLE immediately, with no `card_valid` pulse; the LFSR and deck mask reset too.
- `bin` held high is one request only; a new request needs `bin` low for ≥1 cycle, then high.
- Scan counter wrap-around is silent. The digit period is 2^(SCAN_W-1) cycles.

## Configuration
- Macro `POKER_DECK_NO_REPEAT_EN`.
- Defined:
  - A CARD_MAX-bit `used` mask sets the bit for each accepted card.
  - Candidates whose bit is set are rejected.
  - When the accepted card completes the mask (all ones), the mask clears on the same DONE edge, starting a new deck.
  - Fallback picks the lowest clear bit.
- Undefined: no mask, no logic; cards may repeat, and fallback uses the mod formula.

## Test plan
- Reset: assert `clr` asynchronously mid-cycle → `card`=0, `am`=1110, `out`=00000011, `busy`=0 immediately. Release, then run 2^SCAN_W cycles → `am` alternates 1110/1101 with `out`=00000011 on both.
- Single draw: pulse `bin` → `busy` rises, `card_valid` fires exactly once within 3..18 cycles, and 1 ≤ `card` ≤ 13. Check the LFSR sequence against a reference model from SEED=1.
- Display decode: force `card`=12 via a draw that model-predicts 12 → tens digit `out`=10011111, ones digit `out`=00100101.
- Fallback: with CARD_MAX=2 and MAX_TRIES=0, draw when the model's `cand`=3 → `card`=(3 mod 2)+1=2 at minimum latency.
- Request rules: hold `bin` high 50 cycles → one `card_valid`. Pulse `bin` while `busy` → ignored. Assert `clr` during DRAW → no `card_valid`, `card`=0.
- With `POKER_DECK_NO_REPEAT_EN`: 26 draws → cards 1..13 each appear exactly once in draws 1–13 and again in 14–26; the mask reads 0 after draw 13.
